// File: rtl/pic_port_bank_if.sv
// CPU-side register bus for pic_port_bank: write strobe/target/data plus the
// combinational read-back of a selected port's synchronized pin value.
interface pic_port_bank_if #(
  parameter int SEL_W      = 2,
  parameter int PORT_WIDTH = 8
);
  logic                  wr_en;
  logic [1:0]            wr_sel;
  logic [SEL_W-1:0]      wr_port;
  logic [PORT_WIDTH-1:0] wr_data;
  logic [SEL_W-1:0]      rd_port;
  logic [PORT_WIDTH-1:0] rd_data;

  modport master (
    output wr_en, wr_sel, wr_port, wr_data, rd_port,
    input  rd_data
  );

  modport slave (
    input  wr_en, wr_sel, wr_port, wr_data, rd_port,
    output rd_data
  );
endinterface

// File: rtl/pic_port_bank.sv
// Parametrised bank of bidirectional I/O ports: output latch, TRIS, pad input
// synchronizer and interrupt-on-change with per-bit enable for each port.
module pic_port_bank #(
  parameter int NUM_PORTS   = 3,
  parameter int PORT_WIDTH  = 8,
  parameter int SYNC_STAGES = 2,
  parameter int SEL_W       = 2
) (
  input  logic                            clk,
  input  logic                            rst,
  pic_port_bank_if.slave                  bus,
  input  logic [NUM_PORTS*PORT_WIDTH-1:0] pad_in,
  output logic [NUM_PORTS*PORT_WIDTH-1:0] pad_out,
  output logic [NUM_PORTS*PORT_WIDTH-1:0] pad_oe,
  input  logic                            ioc_clr,
  output logic [NUM_PORTS-1:0]            ioc_pending,
  output logic                            ioc_flag
);

  localparam int TOT   = NUM_PORTS * PORT_WIDTH;
  localparam int CNT_W = $clog2(SYNC_STAGES + 2);
  localparam logic [CNT_W-1:0] WARM_MAX = CNT_W'(SYNC_STAGES + 1);

  logic [TOT-1:0]       latch_q;
  logic [TOT-1:0]       tris_q;
  logic [TOT-1:0]       ien_q;
  logic [TOT-1:0]       sync_q [SYNC_STAGES];
  logic [TOT-1:0]       prev_q;
  logic [CNT_W-1:0]     warm_cnt;
  logic                 warm_done;
  logic [TOT-1:0]       bit_evt;
  logic [NUM_PORTS-1:0] port_evt;

  // Only an in-range port index can match, so out-of-range writes fall through.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      latch_q <= '0;
      tris_q  <= '1;
      ien_q   <= '0;
    end else if (bus.wr_en) begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (bus.wr_port == SEL_W'(p)) begin
          case (bus.wr_sel)
            2'd0:    latch_q[p*PORT_WIDTH +: PORT_WIDTH] <= bus.wr_data;
            2'd1:    tris_q[p*PORT_WIDTH +: PORT_WIDTH]  <= bus.wr_data;
            2'd2:    ien_q[p*PORT_WIDTH +: PORT_WIDTH]   <= bus.wr_data;
            default: latch_q[p*PORT_WIDTH +: PORT_WIDTH] <=
                       latch_q[p*PORT_WIDTH +: PORT_WIDTH] ^ bus.wr_data;
          endcase
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      prev_q <= '0;
    end else begin
      sync_q[0] <= pad_in;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  // Masks the spurious edge seen while the freshly cleared chain fills with pad data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      warm_cnt <= '0;
    end else if (warm_cnt != WARM_MAX) begin
      warm_cnt <= warm_cnt + 1'b1;
    end
  end

  assign warm_done = (warm_cnt == WARM_MAX);
  assign bit_evt   = (sync_q[SYNC_STAGES-1] ^ prev_q) & ien_q & tris_q;

  always_comb begin
    port_evt = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      port_evt[p] = |bit_evt[p*PORT_WIDTH +: PORT_WIDTH];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ioc_pending <= '0;
    end else begin
      ioc_pending <= (ioc_pending & ~{NUM_PORTS{ioc_clr}})
                   | (port_evt & {NUM_PORTS{warm_done}});
    end
  end

  always_comb begin
    bus.rd_data = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (bus.rd_port == SEL_W'(p)) begin
        bus.rd_data = sync_q[SYNC_STAGES-1][p*PORT_WIDTH +: PORT_WIDTH];
      end
    end
  end

  assign pad_out  = latch_q;
  assign pad_oe   = ~tris_q;
  assign ioc_flag = |ioc_pending;

endmodule
